// File: rtl/axi_text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axi_text_buffer
// Brief    : AXI4-Lite slave holding the VGA character map and attribute plane,
//            with a display read port and a hardware clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module axi_text_buffer #(
    parameter int          COLS             = 80,
    parameter int          ROWS             = 30,
    parameter int          CHAR_BITS        = 7,
    parameter int          OPT_ATTR         = 1,
    parameter logic [7:0]  FILL_CHAR        = 8'h20,
    parameter logic [7:0]  DEFAULT_ATTR     = 8'h0F,
    parameter int          C_AXI_ADDR_WIDTH = 13,
    parameter int          C_AXI_DATA_WIDTH = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    output logic [1:0]                    S_AXI_BRESP,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    input  logic [$clog2(COLS*ROWS)-1:0]  disp_addr_i,
    output logic [7:0]                    disp_char_o,
    output logic [7:0]                    disp_attr_o,
    input  logic                          clear_i,
    output logic                          busy_o
);

    localparam int c_cells  = COLS * ROWS;
    localparam int c_depth  = (c_cells + 3) / 4;
    localparam int c_idx_w  = $clog2(c_cells);
    localparam int c_widx_w = C_AXI_ADDR_WIDTH - 3;
    localparam int c_mem_aw = (c_depth > 1) ? $clog2(c_depth) : 1;

    localparam logic [c_idx_w:0]    c_cells_v   = (c_idx_w + 1)'(c_cells);
    localparam logic [c_widx_w:0]   c_depth_v   = (c_widx_w + 1)'(c_depth);
    localparam logic [c_mem_aw-1:0] c_last      = c_mem_aw'(c_depth - 1);
    localparam logic [7:0]          c_char_mask = 8'((16'd1 << CHAR_BITS) - 16'd1);
    localparam logic [7:0]          c_fill      = FILL_CHAR & c_char_mask;

    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_mem_aw-1:0]   r_clr_cnt;
    logic [c_mem_aw-1:0]   w_clr_cnt_nxt;
    logic                  w_busy;
    logic                  w_clr_we;

    logic                  r_awready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic [7:0]            r_disp_char;
    logic [7:0]            r_disp_attr;

    logic                  w_wr_fire;
    logic                  w_aw_plane;
    logic [c_widx_w-1:0]   w_aw_widx;
    logic [c_mem_aw-1:0]   w_aw_midx;
    logic                  w_aw_inrange;
    logic [3:0]            w_char_we;
    logic [3:0]            w_attr_we;

    logic                  w_rd_fire;
    logic                  w_ar_plane;
    logic [c_widx_w-1:0]   w_ar_widx;
    logic [c_mem_aw-1:0]   w_ar_midx;
    logic                  w_ar_inrange;
    logic [31:0]           w_rd_word;

    logic                  w_dp_ok;
    logic [c_widx_w-1:0]   w_dp_widx;
    logic [c_mem_aw-1:0]   w_dp_midx;
    logic [1:0]            w_dp_lane;

    logic [7:0]            w_ar_char [4];
    logic [7:0]            w_ar_attr [4];
    logic [7:0]            w_dp_char [4];
    logic [7:0]            w_dp_attr [4];

    // ------------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear_i) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == c_last) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy   = (r_state == S_CLEAR);
    assign w_clr_we = w_busy;

    // ------------------------------------------------------------------------
    // Write channel: AW and W are only ever accepted together
    // ------------------------------------------------------------------------
    assign w_wr_fire    = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_aw_plane   = S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1];
    assign w_aw_widx    = S_AXI_AWADDR[C_AXI_ADDR_WIDTH-2:2];
    assign w_aw_midx    = w_aw_widx[c_mem_aw-1:0];
    assign w_aw_inrange = ({1'b0, w_aw_widx} < c_depth_v);

    always_comb begin
        w_char_we = '0;
        w_attr_we = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_wr_fire && w_aw_inrange && S_AXI_WSTRB[i] &&
                ({1'b0, w_aw_widx, 2'(i)} < c_cells_v)) begin
                if (w_aw_plane) w_attr_we[i] = 1'b1;
                else            w_char_we[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
        end else begin
            r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_awready &
                         (~r_bvalid | S_AXI_BREADY) & ~w_busy;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_inrange ? c_okay : c_slverr;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Byte-lane storage; the clear engine takes priority over an AXI write
    // landing on the very first clear cycle since that word is refilled anyway
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_char_mem [c_depth];

            always_ff @(posedge S_AXI_ACLK) begin
                if (w_clr_we)
                    r_char_mem[r_clr_cnt] <= c_fill;
                else if (w_char_we[gi])
                    r_char_mem[w_aw_midx] <= S_AXI_WDATA[8*gi +: 8] & c_char_mask;
            end

            assign w_ar_char[gi] = r_char_mem[w_ar_midx];
            assign w_dp_char[gi] = r_char_mem[w_dp_midx];

            if (OPT_ATTR != 0) begin : g_attr
                logic [7:0] r_attr_mem [c_depth];

                always_ff @(posedge S_AXI_ACLK) begin
                    if (w_clr_we)
                        r_attr_mem[r_clr_cnt] <= DEFAULT_ATTR;
                    else if (w_attr_we[gi])
                        r_attr_mem[w_aw_midx] <= S_AXI_WDATA[8*gi +: 8];
                end

                assign w_ar_attr[gi] = r_attr_mem[w_ar_midx];
                assign w_dp_attr[gi] = r_attr_mem[w_dp_midx];
            end else begin : g_no_attr
                logic w_unused_attr;
                assign w_unused_attr = &{1'b0, w_attr_we[gi]};
                assign w_ar_attr[gi] = 8'h00;
                assign w_dp_attr[gi] = 8'h00;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    assign S_AXI_ARREADY = ~w_busy & (~r_rvalid | S_AXI_RREADY);
    assign w_rd_fire     = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_ar_plane    = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1];
    assign w_ar_widx     = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-2:2];
    assign w_ar_midx     = w_ar_widx[c_mem_aw-1:0];
    assign w_ar_inrange  = ({1'b0, w_ar_widx} < c_depth_v);

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if ({1'b0, w_ar_widx, 2'(i)} < c_cells_v)
                w_rd_word[8*i +: 8] = w_ar_plane ? w_ar_attr[i] : w_ar_char[i];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_okay;
        end else if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_inrange ? w_rd_word : 32'h0;
            r_rresp  <= w_ar_inrange ? c_okay : c_slverr;
        end else if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Display port
    // ------------------------------------------------------------------------
    assign w_dp_ok   = ({1'b0, disp_addr_i} < c_cells_v);
    assign w_dp_widx = disp_addr_i[c_idx_w-1:2];
    assign w_dp_midx = w_dp_widx[c_mem_aw-1:0];
    assign w_dp_lane = disp_addr_i[1:0];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_disp_char <= 8'h00;
            r_disp_attr <= 8'h00;
        end else begin
            r_disp_char <= w_dp_ok ? w_dp_char[w_dp_lane] : 8'h00;
            r_disp_attr <= w_dp_ok ? w_dp_attr[w_dp_lane] : 8'h00;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign disp_char_o   = r_disp_char;
    assign disp_attr_o   = r_disp_attr;
    assign busy_o        = w_busy;

    logic w_unused;
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire
